tlut_period_cnt: RTL

Parametrised period counter that generates the time base for temporal-LUT lanes. It generalises the fixed-width, free-running, all-ones rollover counter. Additions: programmable terminal count, three counting modes (free-run, one-shot, up/down triangle), synchronous clear, a registered Gray-coded output, and a saturating epoch counter. Reset defaults reproduce the legacy behaviour: binary up-count, wrap at all-ones.

---
 rtl/tlut_pkg.sv | 6 +
 rtl/tlut_bin2gray.sv | 9 +
 rtl/tlut_period_cnt.sv | 84 ++++++++
 3 files changed

// File: rtl/tlut_pkg.sv
// tlut_pkg: shared mode encoding and reset defaults for the temporal-LUT period counter
package tlut_pkg;
  typedef enum logic [1:0] {CM_FREE, CM_ONESHOT, CM_UPDOWN, CM_RSVD} cnt_mode_e;
  localparam cnt_mode_e MODE_RST = CM_FREE;
  localparam logic DIR_UP = 1'b0;
endpackage

// File: rtl/tlut_bin2gray.sv
// tlut_bin2gray: combinational binary to Gray code converter
module tlut_bin2gray #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/tlut_period_cnt.sv
// tlut_period_cnt: programmable period counter (free-run, one-shot, triangle) with Gray output and epoch count
module tlut_period_cnt
  import tlut_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic [1:0]         cfg_mode,
  input  logic [WIDTH-1:0]   cfg_term,
  output logic [WIDTH-1:0]   cnt_out,
  output logic [WIDTH-1:0]   cnt_gray,
  output logic               at_term,
  output logic               wrap,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch
);
  cnt_mode_e          r_mode;
  logic [WIDTH-1:0]   r_term, r_cnt, r_gray, w_cnt_nxt, w_gray;
  logic               r_down, w_down_nxt, w_free, w_top, w_zero;
  logic [EPOCH_W-1:0] r_epoch;
  assign w_free  = (r_mode == CM_FREE) || (r_mode == CM_RSVD);
  assign w_top   = r_cnt >= r_term;
  assign w_zero  = r_cnt == '0;
  assign at_term = r_cnt == r_term;
  assign done    = (r_mode == CM_ONESHOT) && at_term;
  assign cnt_out  = r_cnt;
  assign cnt_gray = r_gray;
  assign epoch    = r_epoch;
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_down_nxt = r_down;
    wrap       = 1'b0;
    if (enable) begin
      if (w_free) begin
        wrap      = w_top;
        w_cnt_nxt = w_top ? '0 : r_cnt + WIDTH'(1);
      end else if (r_mode == CM_ONESHOT) begin
        w_cnt_nxt = w_top ? r_cnt : r_cnt + WIDTH'(1);
      end else if (r_term == '0) begin
        wrap      = 1'b1;
        w_cnt_nxt = '0;
      end else if (r_down == DIR_UP) begin
        w_cnt_nxt  = w_top ? r_term - WIDTH'(1) : r_cnt + WIDTH'(1);
        w_down_nxt = w_top;
      end else begin
        // bottom of the triangle closes the period and turns straight back up
        wrap       = w_zero;
        w_cnt_nxt  = w_zero ? WIDTH'(1) : r_cnt - WIDTH'(1);
        w_down_nxt = !w_zero;
      end
    end
  end
  tlut_bin2gray #(.WIDTH(WIDTH)) u_b2g (.i_bin(w_cnt_nxt), .o_gray(w_gray));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_RST;
      r_term  <= '1;
      r_cnt   <= '0;
      r_gray  <= '0;
      r_down  <= DIR_UP;
      r_epoch <= '0;
    end else if (clear) begin
      r_mode  <= cnt_mode_e'(cfg_mode);
      r_term  <= cfg_term;
      r_cnt   <= '0;
      r_gray  <= '0;
      r_down  <= DIR_UP;
      r_epoch <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_gray <= w_gray;
      r_down <= w_down_nxt;
      if (wrap) begin
        r_mode  <= cnt_mode_e'(cfg_mode);
        r_term  <= cfg_term;
        r_epoch <= (r_epoch == '1) ? r_epoch : r_epoch + EPOCH_W'(1);
      end
    end
  end
endmodule
